// File: rtl/pipe_hazard_if.sv
// ID-stage bundle between the decode datapath and the hazard/forwarding unit.
// The master is the ID stage; the slave is the hazard unit.
interface pipe_hazard_if #(
   parameter int XLEN  = 32,
   parameter int RAW   = 5,
   parameter int DEPTH = 3,
   parameter int CNT_W = 16
);
   logic                    id_valid;
   logic [RAW-1:0]          id_rs1_sel;
   logic [RAW-1:0]          id_rs2_sel;
   logic                    id_rs1_used;
   logic                    id_rs2_used;
   logic                    id_regwrite;
   logic [RAW-1:0]          id_rd;
   logic                    id_is_load;
   logic                    id_branch_taken;
   logic [XLEN-1:0]         rf_rs1;
   logic [XLEN-1:0]         rf_rs2;
   logic [DEPTH*XLEN-1:0]   fwd_data;
   logic [XLEN-1:0]         op_a;
   logic [XLEN-1:0]         op_b;
   logic                    fwd_hit_a;
   logic                    fwd_hit_b;
   logic                    stall;
   logic                    kill_id;
   logic [CNT_W-1:0]        stall_cnt;

   modport master (
      output id_valid, id_rs1_sel, id_rs2_sel, id_rs1_used, id_rs2_used,
             id_regwrite, id_rd, id_is_load, id_branch_taken,
             rf_rs1, rf_rs2, fwd_data,
      input  op_a, op_b, fwd_hit_a, fwd_hit_b, stall, kill_id, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1_sel, id_rs2_sel, id_rs1_used, id_rs2_used,
             id_regwrite, id_rd, id_is_load, id_branch_taken,
             rf_rs1, rf_rs2, fwd_data,
      output op_a, op_b, fwd_hit_a, fwd_hit_b, stall, kill_id, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand forwarding for the in-order DLX pipeline.
// Tracks destination tags for DEPTH stages after ID and resolves RAW hazards.
module pipe_hazard_unit #(
   parameter int XLEN     = 32,
   parameter int RAW      = 5,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input logic          clk,
   input logic          rst_n,
   pipe_hazard_if.slave bus
);

   typedef struct packed {
      logic            hit;
      logic            haz;
      logic [XLEN-1:0] data;
   } res_t;

   logic [DEPTH-1:0] sh_v;
   logic [DEPTH-1:0] sh_ld;
   logic [RAW-1:0]   sh_rd [DEPTH];
   logic             kill_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             stall;
   logic             v_new;
   res_t             res_a;
   res_t             res_b;

   // Oldest-to-youngest scan so the youngest matching stage overwrites older ones.
   function automatic res_t resolve(input logic [RAW-1:0] sel, input logic used,
                                    input logic [XLEN-1:0] rf);
      res_t r;
      logic found;
      logic ready;
      logic [XLEN-1:0] data;
      found = 1'b0;
      ready = 1'b0;
      data  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (sh_v[k] && sh_rd[k] == sel) begin
            found = 1'b1;
            ready = ~sh_ld[k] | (k >= LOAD_LAT);
            data  = bus.fwd_data[k*XLEN +: XLEN];
         end
      end
      found  = found & used & (sel != '0);
      r.hit  = found & ready;
      r.haz  = found & ~ready;
      r.data = (found & ready) ? data : rf;
      return r;
   endfunction

   always_comb begin
      res_a = resolve(bus.id_rs1_sel, bus.id_rs1_used, bus.rf_rs1);
      res_b = resolve(bus.id_rs2_sel, bus.id_rs2_used, bus.rf_rs2);
   end

   assign stall = bus.id_valid & ~kill_q & (res_a.haz | res_b.haz);
   assign v_new = bus.id_valid & bus.id_regwrite & ~stall & ~kill_q &
                  (bus.id_rd != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_v        <= '0;
         kill_q      <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         sh_v   <= {sh_v[DEPTH-2:0], v_new};
         kill_q <= bus.id_valid & bus.id_branch_taken & ~stall & ~kill_q;
         if (stall && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   // NOTE: tag payload is qualified by sh_v, so it needs no reset and stays plain flops.
   always_ff @(posedge clk) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
         sh_rd[k] <= sh_rd[k-1];
         sh_ld[k] <= sh_ld[k-1];
      end
      sh_rd[0] <= bus.id_rd;
      sh_ld[0] <= bus.id_is_load;
   end

   assign bus.op_a      = res_a.data;
   assign bus.op_b      = res_b.data;
   assign bus.fwd_hit_a = res_a.hit;
   assign bus.fwd_hit_b = res_b.hit;
   assign bus.stall     = stall;
   assign bus.kill_id   = kill_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: u1 is DEPTH=3/LOAD_LAT=1, u2 is DEPTH=4/LOAD_LAT=2.
module tb_pipe_hazard_unit;

   localparam int XLEN = 32;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   pipe_hazard_if #(.XLEN(XLEN), .RAW(5), .DEPTH(3), .CNT_W(16)) if1 ();
   pipe_hazard_if #(.XLEN(XLEN), .RAW(5), .DEPTH(4), .CNT_W(16)) if2 ();

   pipe_hazard_unit #(.XLEN(XLEN), .RAW(5), .DEPTH(3), .LOAD_LAT(1), .CNT_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(if1)
   );
   pipe_hazard_unit #(.XLEN(XLEN), .RAW(5), .DEPTH(4), .LOAD_LAT(2), .CNT_W(16)) u2 (
      .clk(clk), .rst_n(rst_n), .bus(if2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if1.id_valid = 0; if1.id_rs1_sel = 0; if1.id_rs2_sel = 0;
      if1.id_rs1_used = 0; if1.id_rs2_used = 0; if1.id_regwrite = 0;
      if1.id_rd = 0; if1.id_is_load = 0; if1.id_branch_taken = 0;
      if1.rf_rs1 = 0; if1.rf_rs2 = 0; if1.fwd_data = '0;
      if2.id_valid = 0; if2.id_rs1_sel = 0; if2.id_rs2_sel = 0;
      if2.id_rs1_used = 0; if2.id_rs2_used = 0; if2.id_regwrite = 0;
      if2.id_rd = 0; if2.id_is_load = 0; if2.id_branch_taken = 0;
      if2.rf_rs1 = 0; if2.rf_rs2 = 0; if2.fwd_data = '0;
   endtask

   task automatic flush();
      idle();
      repeat (5) tick();
   endtask

   // Issue a register writer on u1 and advance one cycle.
   task automatic issue1(input logic [4:0] rd, input logic ld);
      idle();
      if1.id_valid = 1; if1.id_regwrite = 1; if1.id_rd = rd; if1.id_is_load = ld;
      tick();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      if1.id_valid = 1; if1.id_branch_taken = 1;
      if2.id_valid = 1; if2.id_branch_taken = 1;
      tick();
      tick();
      chk("reset_stall", {31'b0, if1.stall}, 0);
      chk("reset_kill", {31'b0, if1.kill_id}, 0);
      chk("reset_cnt", {16'b0, if1.stall_cnt}, 0);
      chk("reset_cnt2", {16'b0, if2.stall_cnt}, 0);
      rst_n = 1;
      idle();
      tick();
      chk("post_reset_kill", {31'b0, if1.kill_id}, 0);
      if1.id_rs1_sel = 3; if1.id_rs1_used = 1; if1.rf_rs1 = 32'h1234_5678;
      if1.rf_rs2 = 32'h0000_ABCD;
      #1;
      chk("post_reset_op_a", if1.op_a, 32'h1234_5678);
      chk("post_reset_op_b", if1.op_b, 32'h0000_ABCD);
      chk("post_reset_hit_a", {31'b0, if1.fwd_hit_a}, 0);
   endtask

   task automatic test_alu_fwd();
      flush();
      issue1(3, 0);
      idle();
      if1.id_valid = 1; if1.id_rs1_sel = 3; if1.id_rs1_used = 1;
      if1.rf_rs1 = 32'h55; if1.fwd_data[31:0] = 32'h0000_00AA;
      #1;
      chk("alu_op_a", if1.op_a, 32'hAA);
      chk("alu_hit_a", {31'b0, if1.fwd_hit_a}, 1);
      chk("alu_stall", {31'b0, if1.stall}, 0);
   endtask

   task automatic test_youngest();
      flush();
      issue1(5, 0);
      issue1(5, 0);
      idle();
      if1.id_valid = 1; if1.id_rs2_sel = 5; if1.id_rs2_used = 1;
      if1.rf_rs2 = 32'h99;
      if1.fwd_data[31:0] = 32'h11; if1.fwd_data[63:32] = 32'h22;
      #1;
      chk("young_op_b", if1.op_b, 32'h11);
      chk("young_hit_b", {31'b0, if1.fwd_hit_b}, 1);
      chk("young_hit_a_unused", {31'b0, if1.fwd_hit_a}, 0);
   endtask

   task automatic test_load_use_lat1();
      int n;
      flush();
      issue1(7, 1);
      idle();
      if1.id_valid = 1; if1.id_rs1_sel = 7; if1.id_rs1_used = 1;
      if1.rf_rs1 = 32'h1; if1.fwd_data[63:32] = 32'hDEAD_BEEF;
      #1;
      chk("lu1_stall_first", {31'b0, if1.stall}, 1);
      n = 0;
      while (if1.stall && n < 10) begin
         n++;
         tick();
      end
      chk("lu1_stall_cycles", n, 1);
      chk("lu1_op_a", if1.op_a, 32'hDEAD_BEEF);
      chk("lu1_hit_a", {31'b0, if1.fwd_hit_a}, 1);
      chk("lu1_cnt", {16'b0, if1.stall_cnt}, 1);
   endtask

   task automatic test_load_use_lat2();
      int n;
      idle();
      repeat (5) tick();
      if2.id_valid = 1; if2.id_regwrite = 1; if2.id_rd = 7; if2.id_is_load = 1;
      tick();
      idle();
      if2.id_valid = 1; if2.id_rs1_sel = 7; if2.id_rs1_used = 1;
      if2.rf_rs1 = 32'h1; if2.fwd_data[95:64] = 32'hCAFE_F00D;
      if2.fwd_data[63:32] = 32'h0BAD_0BAD;
      #1;
      n = 0;
      while (if2.stall && n < 10) begin
         n++;
         tick();
      end
      chk("lu2_stall_cycles", n, 2);
      chk("lu2_op_a", if2.op_a, 32'hCAFE_F00D);
      chk("lu2_hit_a", {31'b0, if2.fwd_hit_a}, 1);
      chk("lu2_cnt", {16'b0, if2.stall_cnt}, 2);
   endtask

   task automatic test_branch_kill();
      flush();
      if1.id_valid = 1; if1.id_branch_taken = 1;
      #1;
      chk("br_kill_before", {31'b0, if1.kill_id}, 0);
      tick();
      // Wrong-path writer of r9, itself claiming a taken branch.
      idle();
      if1.id_valid = 1; if1.id_regwrite = 1; if1.id_rd = 9; if1.id_branch_taken = 1;
      #1;
      chk("br_kill_on", {31'b0, if1.kill_id}, 1);
      chk("br_killed_stall", {31'b0, if1.stall}, 0);
      tick();
      idle();
      if1.id_valid = 1; if1.id_rs1_sel = 9; if1.id_rs1_used = 1;
      if1.rf_rs1 = 32'h999; if1.fwd_data[31:0] = 32'h777;
      #1;
      chk("br_kill_one_cycle", {31'b0, if1.kill_id}, 0);
      chk("br_r9_hit", {31'b0, if1.fwd_hit_a}, 0);
      chk("br_r9_op_a", if1.op_a, 32'h999);
   endtask

   task automatic test_branch_vs_stall();
      flush();
      issue1(7, 1);
      idle();
      if1.id_valid = 1; if1.id_rs1_sel = 7; if1.id_rs1_used = 1; if1.id_branch_taken = 1;
      #1;
      chk("bs_stall", {31'b0, if1.stall}, 1);
      tick();
      chk("bs_no_kill_yet", {31'b0, if1.kill_id}, 0);
      chk("bs_stall_done", {31'b0, if1.stall}, 0);
      tick();
      idle();
      #1;
      chk("bs_kill_armed", {31'b0, if1.kill_id}, 1);
      chk("bs_cnt", {16'b0, if1.stall_cnt}, 2);
   endtask

   task automatic test_r0();
      flush();
      issue1(0, 1);
      idle();
      if1.id_valid = 1; if1.id_rs1_sel = 0; if1.id_rs1_used = 1;
      if1.rf_rs1 = 32'h0; if1.fwd_data[31:0] = 32'hBAD;
      #1;
      chk("r0_hit", {31'b0, if1.fwd_hit_a}, 0);
      chk("r0_op_a", if1.op_a, 32'h0);
      chk("r0_stall", {31'b0, if1.stall}, 0);
   endtask

   task automatic test_reset_mid_stall();
      flush();
      issue1(7, 1);
      idle();
      if1.id_valid = 1; if1.id_rs2_sel = 7; if1.id_rs2_used = 1;
      #1;
      chk("rms_stall_before", {31'b0, if1.stall}, 1);
      rst_n = 0;
      tick();
      chk("rms_stall_after", {31'b0, if1.stall}, 0);
      chk("rms_cnt", {16'b0, if1.stall_cnt}, 0);
      rst_n = 1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1;
      idle();
      test_reset();
      test_alu_fwd();
      test_youngest();
      test_load_use_lat1();
      test_load_use_lat2();
      test_branch_kill();
      test_branch_vs_stall();
      test_r0();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard-detection and operand-forwarding unit for the in-order DLX pipeline.
- Keeps its own shadow pipeline of destination-register and load tags for DEPTH stages after ID.
- Resolves RAW hazards by youngest-match forwarding, or by load-use stalls sized from LOAD_LAT.
- Kills the wrong-path ID instruction after a taken branch.
- Sits beside the ID stage; drives the ID operand muxes, the PC/IF-ID hold, and bubble insertion into EX.

Parameters:
- XLEN, 32, datapath width.
- RAW, 5, register address width (2^RAW architectural registers).
- DEPTH, 3, number of tracked stages after ID (index 0 = EX, DEPTH-1 = WB); range 2..6.
- LOAD_LAT, 1, lowest stage index at which load data is valid on fwd_data; must be < DEPTH.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_sel, id_rs2_sel  in  RAW each  ID source register selects.
- id_rs1_used, id_rs2_used  in  1 each  the source is actually read.
- id_regwrite  in  1  ID instruction writes a register.
- id_rd  in  RAW  ID destination register.
- id_is_load  in  1  ID instruction is a load.
- id_branch_taken  in  1  ID resolves a taken branch or jump.
- rf_rs1, rf_rs2  in  XLEN each  register-file read data.
- fwd_data  in  DEPTH*XLEN  per-stage writeback-candidate value; slice k is stage k.
- op_a, op_b  out  XLEN each  resolved ID operands.
- fwd_hit_a, fwd_hit_b  out  1 each  the operand came from fwd_data.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- kill_id  out  1  current ID instruction is wrong-path; treat it as a bubble.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow entry k holds {v, rd, ld}. On reset, every v=0, kill register=0 and stall_cnt=0.
- Reset state outputs: stall=0, kill_id=0, fwd_hit_*=0, op_a=rf_rs1, op_b=rf_rs2.
- Shift each cycle: entry k+1 <= entry k, and the WB entry drops out. Entry 0 is loaded as follows:
  - v = id_valid & id_regwrite & ~stall & ~kill_id & (id_rd != 0); rd = id_rd; ld = id_is_load.
  - A stall or kill therefore inserts a bubble.
- Operand match for source s: the youngest k (smallest index) with v[k] & rd[k]==s. Requires s != 0 and the used bit set.
  - No match: operand = rf value, hit=0.
  - Match, and value valid (~ld[k] | k >= LOAD_LAT): operand = fwd_data slice k, hit=1.
  - Match, value not yet valid: load-use hazard. Operand is don't-care; hit=0.
  - Register 0 never matches; its operand is always rf value, which reads 0.
- stall = id_valid & ~kill_id & (load-use hazard on a or b). Combinational, no latency.
- A load in EX stalls LOAD_LAT cycles on a dependent ID. The bubbles advance the load until k = LOAD_LAT, and then the operand is forwarded.
- Kill:
  - Kill register <= id_valid & id_branch_taken & ~stall & ~kill_id. kill_id = kill register.
  - kill_id is exactly one cycle wide.
  - A killed ID never stalls. Its id_branch_taken is ignored, so back-to-back kills cannot occur.
- Simultaneous branch and stall: stall wins. The kill is not armed until the branch instruction issues un-stalled.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones. It is cleared only by reset.
- Reset asserted mid-stall: the next edge clears the shadow state, so stall drops the cycle after.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 and id_branch_taken=1 -> stall=0, kill_id=0, stall_cnt=0. After release, op_a=rf_rs1.
- ALU back-to-back: issue "r3=…" then ID reads r3 with fwd_data[EX]=0x0000_00AA -> op_a=0xAA, fwd_hit_a=1, stall=0.
- Youngest match: r5 is in EX (fwd_data[0]=0x11) and in MEM (fwd_data[1]=0x22), ID reads r5 -> op_b=0x11.
- Load-use, LOAD_LAT=1:
  - Load r7 followed by a reader of r7 -> stall=1 for exactly 1 cycle.
  - Next cycle op_a=fwd_data[1]=0xDEAD_BEEF.
  - stall_cnt=1.
- Load-use, LOAD_LAT=2, DEPTH=4: the same sequence -> stall for 2 cycles, stall_cnt=2. Then op_a=fwd_data[2].
- Taken branch:
  - id_branch_taken=1 -> kill_id=1 for one cycle. The killed instruction has regwrite=1, rd=r9.
  - The next reader of r9 gets fwd_hit=0 and the rf value.
  - r0 writer followed by a reader of r0 -> hit=0, no stall.
